alu_operand_stage: RTL

- Decode/execute pipeline register that sits directly upstream of the ALU.
- Captures the decoded operation and register-file operands, then resolves data hazards by forwarding from the two later pipeline stages.
- Selects register or immediate for operand B and drives registered alu_ctrl/src_A/src_B to the ALU.
- Supports stall (hold) and flush (bubble insertion).

---
 rtl/alu_operand_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Decode/execute pipeline register ahead of the ALU: resolves operand hazards by
// forwarding from EX/MEM and MEM/WB, selects immediate for B, and supports stall/flush.
module alu_operand_stage #(
    parameter int N  = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [5:0]    id_alu_ctrl,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_use_imm,
    input  logic [N-1:0]  id_rf_a,
    input  logic [N-1:0]  id_rf_b,
    input  logic [N-1:0]  id_imm,
    input  logic          exm_valid,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_rd,
    input  logic [N-1:0]  exm_result,
    input  logic          mwb_valid,
    input  logic          mwb_reg_write,
    input  logic [RW-1:0] mwb_rd,
    input  logic [N-1:0]  mwb_result,
    output logic          ex_valid,
    output logic [5:0]    alu_ctrl,
    output logic [N-1:0]  src_A,
    output logic [N-1:0]  src_B,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          illegal_op
);

    // The younger producer (EX/MEM) wins; register 0 always reads the register file.
    function automatic logic [N-1:0] fwd_operand(
        input logic [RW-1:0] rs,
        input logic [N-1:0]  rf_val,
        input logic          exm_wr,
        input logic [RW-1:0] exm_dst,
        input logic [N-1:0]  exm_val,
        input logic          mwb_wr,
        input logic [RW-1:0] mwb_dst,
        input logic [N-1:0]  mwb_val
    );
        logic [N-1:0] res;
        res = rf_val;
        if (rs != '0) begin
            if (exm_wr && exm_dst == rs)
                res = exm_val;
            else if (mwb_wr && mwb_dst == rs)
                res = mwb_val;
        end
        return res;
    endfunction

    function automatic logic is_legal(input logic [5:0] code);
        logic ok;
        case (code)
            6'd1, 6'd2, 6'd3, 6'd4, 6'd9, 6'd10, 6'd11, 6'd12: ok = 1'b1;
            default:                                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic          exm_wr_p0;
    logic          mwb_wr_p0;
    logic          legal_p0;
    logic [N-1:0]  src_a_p0;
    logic [N-1:0]  src_b_p0;

    // Decode-side stage: operand resolution before the ID/EX register
    always_comb begin
        exm_wr_p0 = exm_valid & exm_reg_write;
        mwb_wr_p0 = mwb_valid & mwb_reg_write;
        legal_p0  = is_legal(id_alu_ctrl);
        src_a_p0  = fwd_operand(id_rs1, id_rf_a, exm_wr_p0, exm_rd, exm_result,
                                mwb_wr_p0, mwb_rd, mwb_result);
        if (id_use_imm)
            src_b_p0 = id_imm;
        else
            src_b_p0 = fwd_operand(id_rs2, id_rf_b, exm_wr_p0, exm_rd, exm_result,
                                   mwb_wr_p0, mwb_rd, mwb_result);
    end

    // ID/EX register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            alu_ctrl     <= '0;
            src_A        <= '0;
            src_B        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            illegal_op   <= 1'b0;
        end else if (flush || (!stall && !id_valid)) begin
            ex_valid     <= 1'b0;
            alu_ctrl     <= '0;
            src_A        <= '0;
            src_B        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            illegal_op   <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= 1'b1;
            alu_ctrl     <= legal_p0 ? id_alu_ctrl : 6'd0;
            src_A        <= src_a_p0;
            src_B        <= src_b_p0;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write & legal_p0;
            illegal_op   <= ~legal_p0;
        end
    end

endmodule
